// File: rtl/cordic_tune_pkg.sv
// rtl/cordic_tune_pkg.sv - shared constants and FSM state type for cordic_tune_ctrl
package cordic_tune_pkg;

  localparam int WF_DEF         = 32;
  localparam int NUM_RX_DEF     = 4;
  localparam int CORDIC_LATENCY = 20;
  localparam int CNT_W          = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } tune_state_e;

endpackage

// File: rtl/cordic_freq_bank.sv
// rtl/cordic_freq_bank.sv - one channel's shadow/active tuning-word pair with pend/stage bits
module cordic_freq_bank
  import cordic_tune_pkg::*;
#(
  parameter int WF = WF_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en_i,
  input  logic [WF-1:0] wr_freq_i,
  input  logic          wr_sync_i,
  input  logic          commit_i,
  input  logic          apply_en_i,
  output logic [WF-1:0] shadow_o,
  output logic [WF-1:0] active_o,
  output logic          pending_o,
  output logic          staged_o,
  output logic          pending_next_o,
  output logic          staged_next_o
);

  logic [WF-1:0] shadow_q, shadow_d;
  logic [WF-1:0] active_q, active_d;
  logic          pending_q, pending_d;
  logic          staged_q, staged_d;

  // Order matters: apply samples the old shadow, then sets from commit/accept win over the clear.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    staged_d  = staged_q;
    if (apply_en_i) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (commit_i) begin
      pending_d = pending_d | staged_q | (wr_en_i & wr_sync_i);
      staged_d  = 1'b0;
    end else if (wr_en_i && wr_sync_i) begin
      staged_d = 1'b1;
    end
    if (wr_en_i) begin
      shadow_d = wr_freq_i;
      if (!wr_sync_i) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      staged_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      staged_q  <= staged_d;
    end
  end

  assign shadow_o       = shadow_q;
  assign active_o       = active_q;
  assign pending_o      = pending_q;
  assign staged_o       = staged_q;
  assign pending_next_o = pending_d;
  assign staged_next_o  = staged_d;

endmodule

// File: rtl/cordic_tune_ctrl.sv
// rtl/cordic_tune_ctrl.sv - CORDIC retune controller: shadow banks, strobe-aligned apply, blanking FSM
// Optional readback ports enabled by defining CORDIC_TUNE_READBACK_EN.
module cordic_tune_ctrl
  import cordic_tune_pkg::*;
#(
  parameter int NUM_RX        = NUM_RX_DEF,
  parameter int WF            = WF_DEF,
  parameter int SETTLE_CYCLES = CORDIC_LATENCY,
  parameter int CW            = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_chan,
  input  logic [WF-1:0]        cmd_freq,
  input  logic                 cmd_sync,
  input  logic                 commit,
  input  logic                 apply_strobe,
`ifdef CORDIC_TUNE_READBACK_EN
  input  logic [CW-1:0]        rd_chan,
  output logic [WF-1:0]        rd_active,
  output logic [WF-1:0]        rd_shadow,
`endif
  output logic [NUM_RX*WF-1:0] freq_out,
  output logic [NUM_RX-1:0]    blank,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  tune_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_RX-1:0] blank_q, blank_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q;
  logic              cmd_err_q, cmd_err_d;

  logic [NUM_RX-1:0] chan_hit;
  logic [NUM_RX-1:0] pending_w, staged_w, pending_nx, staged_nx;
  logic [WF-1:0]     shadow_w [NUM_RX];
  logic [WF-1:0]     active_w [NUM_RX];
  logic              accept;
  logic              apply_fire;

  assign accept     = cmd_valid & cmd_ready_q;
  assign apply_fire = (state_q == ST_IDLE) & apply_strobe & (|pending_w);

  for (genvar k = 0; k < NUM_RX; k++) begin : g_bank
    assign chan_hit[k] = (cmd_chan == CW'(k));

    cordic_freq_bank #(.WF(WF)) u_bank (
      .clock          (clock),
      .reset_n        (reset_n),
      .wr_en_i        (accept & chan_hit[k]),
      .wr_freq_i      (cmd_freq),
      .wr_sync_i      (cmd_sync),
      .commit_i       (commit),
      .apply_en_i     (apply_fire & pending_w[k]),
      .shadow_o       (shadow_w[k]),
      .active_o       (active_w[k]),
      .pending_o      (pending_w[k]),
      .staged_o       (staged_w[k]),
      .pending_next_o (pending_nx[k]),
      .staged_next_o  (staged_nx[k])
    );

    assign freq_out[k*WF +: WF] = active_w[k];
  end

  // Strobes arriving in SETTLE are dropped; pending bits simply wait for IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (apply_fire) begin
          blank_d = blank_q | pending_w;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          blank_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_err_d = cmd_err_q | (accept & ~(|chan_hit));
  assign busy_d    = (|pending_nx) | (|staged_nx) | (state_d == ST_SETTLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blank_q     <= '0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign blank     = blank_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;

`ifdef CORDIC_TUNE_READBACK_EN
  logic [WF-1:0] rd_active_q, rd_active_d;
  logic [WF-1:0] rd_shadow_q, rd_shadow_d;

  always_comb begin
    rd_active_d = '0;
    rd_shadow_d = '0;
    for (int k = 0; k < NUM_RX; k++) begin
      if (rd_chan == CW'(k)) begin
        rd_active_d = active_w[k];
        rd_shadow_d = shadow_w[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_active_q <= '0;
      rd_shadow_q <= '0;
    end else begin
      rd_active_q <= rd_active_d;
      rd_shadow_q <= rd_shadow_d;
    end
  end

  assign rd_active = rd_active_q;
  assign rd_shadow = rd_shadow_q;
`endif

endmodule

// File: tb/tb_cordic_tune_ctrl.sv
// tb/tb_cordic_tune_ctrl.sv - self-checking bench: vector table, directed corners, randomized model compare
module tb_cordic_tune_ctrl;

  localparam int NUM_RX = 4;
  localparam int WF     = 32;
  localparam int SETTLE = 20;
  localparam int CW     = 3;
  localparam logic [WF-1:0] F1 = 32'h0A3D70A4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [CW-1:0]        cmd_chan = '0;
  logic [WF-1:0]        cmd_freq = '0;
  logic                 cmd_sync = 1'b0;
  logic                 commit = 1'b0;
  logic                 apply_strobe = 1'b0;
  logic [NUM_RX*WF-1:0] freq_out;
  logic [NUM_RX-1:0]    blank;
  logic                 busy;
  logic                 cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cordic_tune_ctrl #(
    .NUM_RX(NUM_RX), .WF(WF), .SETTLE_CYCLES(SETTLE), .CW(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_freq(cmd_freq), .cmd_sync(cmd_sync), .commit(commit),
    .apply_strobe(apply_strobe), .freq_out(freq_out), .blank(blank), .busy(busy),
    .cmd_err(cmd_err)
  );

  // Reference model: per-channel words and pend/stage sets, blank as a remaining-cycles count.
  logic [WF-1:0]     m_shadow [NUM_RX];
  logic [WF-1:0]     m_active [NUM_RX];
  logic [NUM_RX-1:0] m_pend, m_stage, m_blank;
  int                m_rem;
  bit                m_ready, m_err;

  function automatic logic [NUM_RX*WF-1:0] m_freq();
    logic [NUM_RX*WF-1:0] r;
    for (int k = 0; k < NUM_RX; k++) r[k*WF +: WF] = m_active[k];
    return r;
  endfunction

  function automatic bit m_busy();
    return ((m_pend | m_stage) != 0) || (m_rem > 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_RX; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_pend = '0; m_stage = '0; m_blank = '0;
    m_rem = 0; m_ready = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [NUM_RX-1:0] np;
    int ch;
    np = m_pend;
    ch = int'(cmd_chan);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_blank = '0;
    end else if (apply_strobe && m_pend != 0) begin
      for (int k = 0; k < NUM_RX; k++) if (m_pend[k]) m_active[k] = m_shadow[k];
      m_blank = m_pend;
      m_rem = SETTLE;
      np = '0;
    end
    if (commit) begin
      np = np | m_stage;
      m_stage = '0;
    end
    if (cmd_valid && m_ready) begin
      if (ch < NUM_RX) begin
        m_shadow[ch] = cmd_freq;
        if (!cmd_sync || commit) np[ch] = 1'b1;
        else m_stage[ch] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    m_pend = np;
    m_ready = 1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [CW-1:0] ch, input logic [WF-1:0] f,
                      input logic s, input logic c, input logic a);
    cmd_valid = v; cmd_chan = ch; cmd_freq = f; cmd_sync = s; commit = c; apply_strobe = a;
    @(posedge clock);
    model_edge();
    #1;
    cmd_valid = 1'b0; commit = 1'b0; apply_strobe = 1'b0;
    chk("model_freq", freq_out, m_freq());
    chk("model_blank", blank, m_blank);
    chk("model_busy", busy, m_busy());
    chk("model_err", cmd_err, m_err);
    chk("model_ready", cmd_ready, m_ready);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_settle();
    int n = 0;
    while (m_rem > 0 && n < 40) begin
      idle(1);
      n++;
    end
    chk("settle_bound", (n < 40), 1);
  endtask

  typedef struct {
    int                   pre;
    logic                 v;
    logic [CW-1:0]        ch;
    logic [WF-1:0]        f;
    logic                 s, c, a;
    logic [NUM_RX*WF-1:0] ef;
    logic [NUM_RX-1:0]    eb;
    logic                 ee;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_RX*WF-1:0] f_a, f_b;
    f_a = {32'd0, 32'd0, F1, 32'd0};
    f_b = {32'd0, 32'h200, F1, 32'h100};
    tbl[0]  = '{0,  1'b1, 3'd1, F1,           1'b0, 1'b0, 1'b0, '0,  4'b0000, 1'b0};
    tbl[1]  = '{4,  1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b1, f_a, 4'b0010, 1'b0};
    tbl[2]  = '{18, 1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b0, f_a, 4'b0010, 1'b0};
    tbl[3]  = '{0,  1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b0, f_a, 4'b0000, 1'b0};
    tbl[4]  = '{0,  1'b1, 3'd0, 32'h100,      1'b1, 1'b0, 1'b0, f_a, 4'b0000, 1'b0};
    tbl[5]  = '{0,  1'b1, 3'd2, 32'h200,      1'b1, 1'b0, 1'b0, f_a, 4'b0000, 1'b0};
    tbl[6]  = '{1,  1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b1, f_a, 4'b0000, 1'b0};
    tbl[7]  = '{0,  1'b0, 3'd0, 32'd0,        1'b0, 1'b1, 1'b0, f_a, 4'b0000, 1'b0};
    tbl[8]  = '{1,  1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b1, f_b, 4'b0101, 1'b0};
    tbl[9]  = '{18, 1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b0, f_b, 4'b0101, 1'b0};
    tbl[10] = '{0,  1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 1'b0, f_b, 4'b0000, 1'b0};
    tbl[11] = '{0,  1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, f_b, 4'b0000, 1'b1};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_freq", freq_out, '0);
    chk("reset_blank", blank, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", cmd_err, 1'b0);
    chk("reset_ready", cmd_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    chk("ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      idle(tbl[i].pre);
      step(tbl[i].v, tbl[i].ch, tbl[i].f, tbl[i].s, tbl[i].c, tbl[i].a);
      chk($sformatf("vec%0d_freq", i), freq_out, tbl[i].ef);
      chk($sformatf("vec%0d_blank", i), blank, tbl[i].eb);
      chk($sformatf("vec%0d_err", i), cmd_err, tbl[i].ee);
    end

    // Strobe during SETTLE is dropped; the pending write lands on the first strobe after.
    step(1'b1, 3'd0, 32'h7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd3, 32'h333, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("settle_strobe_ignored", freq_out[127:96], 32'h0);
    wait_settle();
    step(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ch3_after_settle", freq_out[127:96], 32'h333);
    chk("ch3_blank", blank, 4'b1000);

    // Write racing the apply edge: old word goes out, new one stays pending.
    wait_settle();
    step(1'b1, 3'd1, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 32'h55, 1'b0, 1'b0, 1'b1);
    chk("hazard_old_word", freq_out[63:32], 32'h11);
    chk("hazard_busy", busy, 1'b1);
    wait_settle();
    chk("hazard_still_pending", busy, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("hazard_new_word", freq_out[63:32], 32'h55);

    // Reset mid-SETTLE
    wait_settle();
    step(1'b1, 3'd2, 32'hABC, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("pre_reset_blank", blank, 4'b0100);
    reset_n = 1'b0;
    #1;
    chk("async_reset_blank", blank, '0);
    chk("async_reset_freq", freq_out, '0);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_err", cmd_err, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      logic [CW-1:0] ch;
      ch = ($urandom_range(0, 31) == 0) ? 3'd6 : CW'($urandom_range(0, 3));
      step($urandom_range(0, 2) == 0, ch, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_tune_ctrl.md
Name: cordic_tune_ctrl

Overview:
Frequency-tuning controller for the NUM_RX receiver CORDIC mixers. It accepts per-channel tuning-word commands over a valid/ready interface and holds them in shadow registers. It applies them to the CORDIC frequency inputs only on a sample-boundary strobe, either immediately-pending or as a group on commit. For each retuned channel it asserts a blank flag for the CORDIC pipeline latency, so downstream CIC/decimators discard transient samples.

Parameters:
NUM_RX, 4, number of receiver channels / CORDIC instances (1..8)
WF, 32, tuning-word width; matches CORDIC frequency port (-Pi..Pi per clock)
SETTLE_CYCLES, 20, blank length; equals CORDIC phase-register plus 19-stage pipeline latency for IN_WIDTH=16, EXTRA_BITS=4 (1..255)
CW, 3, channel-index width, >= clog2(NUM_RX)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_chan  in  CW  target channel
cmd_freq  in  WF  signed tuning word
cmd_sync  in  1  1 = stage for group commit; 0 = pend for next strobe
commit  in  1  single-cycle pulse: staged mask moves to pending
apply_strobe  in  1  sample-boundary strobe from decimation chain
freq_out  out  NUM_RX*WF  active tuning words, channel k at [k*WF +: WF]; to CORDIC frequency inputs
blank  out  NUM_RX  per-channel output-invalid flag
busy  out  1  high while any bit pending/staged or state SETTLE
cmd_err  out  1  sticky: command to cmd_chan >= NUM_RX

Behaviour:
- Reset, async assert: freq_out=0, shadows=0, pending=0, staged=0, blank=0, busy=0, cmd_err=0, cmd_ready=0, state IDLE, counter 0. cmd_ready=1 from the first clock after reset_n deasserts. It then stays 1; there is no back-pressure in this revision.
- Accept: cmd_freq -> shadow[cmd_chan]. If cmd_sync=0, set pending[chan]; if 1, set staged[chan]. An out-of-range chan is consumed, not stored, and sets cmd_err. cmd_err clears only on reset.
- commit: pending |= staged; staged cleared. On the same-edge accept, the new staged bit is included in the commit.
- States: IDLE, SETTLE.
- IDLE: on an edge with apply_strobe=1 and pending!=0, for each k in pending: freq_out[k] <= shadow[k] and blank[k] <= 1. Then pending cleared, counter <= SETTLE_CYCLES-1, go to SETTLE. freq_out changes are visible on the cycle after the strobe.
- SETTLE: counter decrements each cycle. When the counter reaches 0, blank <= 0 and state goes to IDLE. blank is high exactly SETTLE_CYCLES cycles. apply_strobe is ignored in SETTLE; pending is retained for the first strobe seen in IDLE.
- Same-edge hazard: an accept to channel k on the apply edge updates shadow[k] and sets pending[k]. The apply uses the old shadow value, and the set beats the clear, so k is re-applied later.
- commit and apply_strobe on the same edge: the apply uses pending before the commit. Committed bits apply on the next strobe.
- Channels not in pending keep freq_out and blank unchanged (blank stays 0).
- Arithmetic: no math on tuning words; pass-through only. Counter width 8.
- Reset mid-SETTLE: everything returns to reset values immediately; blank drops asynchronously.
- busy = (pending|staged)!=0 or state==SETTLE, registered.

Optional Feature:
CORDIC_TUNE_READBACK_EN
- Defined: adds inputs rd_chan[CW] and outputs rd_active[WF], rd_shadow[WF]. These are registered with 1-cycle latency and return 0 for out-of-range rd_chan.
- Undefined: ports absent; no readback logic.

Decomposition:
- Package cordic_tune_pkg: WF=32, default NUM_RX, CORDIC_LATENCY=20 constant, state enum (IDLE, SETTLE), counter width.
- Sub-module cordic_freq_bank: one channel's shadow/active register pair with write, pend/stage/commit bits and apply-enable, instantiated NUM_RX times. The FSM and blank counter live in the top module.

Test Plan:
- Reset then idle: freq_out=0, blank=0, busy=0, cmd_ready=1 one cycle after reset_n rises.
- Write ch1=0x0A3D70A4 (sync=0), strobe 5 cycles later: freq_out[1] updates on the cycle after the strobe; blank=4'b0010 for exactly 20 cycles; other channels unchanged.
- Stage ch0=0x100 and ch2=0x200 (sync=1), then strobe: no change. Commit, then strobe: both update on the same cycle; blank=4'b0101 for 20 cycles.
- Write ch3 during SETTLE, then strobe during SETTLE: ignored. The first strobe after blank falls applies ch3.
- Write ch1=0x55 on the same edge as the strobe applying ch1=0x11: freq_out[1]=0x11, pending[1] stays set, next strobe gives 0x55.
- cmd_chan=5 with NUM_RX=4: cmd_err=1 sticky, no register changes. Assert reset_n=0 mid-SETTLE: blank=0 and freq_out=0 immediately.
